pipe_ctrl: RTL and testbench

Central pipeline sequencer for the five-stage core. It collects stall requests from the IF, ID, EX and MEM stages and the exception/ERET redirect from MEM. Each cycle it drives the per-register `stall`/`flush` controls of the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. A small FSM defers the PC redirect while an instruction fetch bus transaction cannot be aborted.

---
 rtl/pipe_ctrl_pkg.sv | 24 ++
 rtl/pipe_ctrl_perf_sat_cnt.sv | 24 ++
 rtl/pipe_ctrl.sv | 127 ++++++++++++
 tb/tb_pipe_ctrl.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared constants for the pipeline sequencer: bus widths, stall/flush bit indices, FSM encoding.
// The optional performance counters are enabled with the PIPE_CTRL_PERF_EN macro.
package pipe_ctrl_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int CTRL_W = 5;

    typedef logic [ADDR_W-1:0] addr_bus_t;
    typedef logic [DATA_W-1:0] data_bus_t;
    typedef logic [CTRL_W-1:0] ctrl_bus_t;

    localparam int PC_IDX    = 0;
    localparam int IFID_IDX  = 1;
    localparam int IDEX_IDX  = 2;
    localparam int EXMEM_IDX = 3;
    localparam int MEMWB_IDX = 4;

    typedef enum logic [0:0] {
        PC_IDLE    = 1'b0,
        PC_WAIT_IF = 1'b1
    } pc_state_e;

endpackage

// File: rtl/pipe_ctrl_perf_sat_cnt.sv
// 32-bit saturating event counter with increment enable and synchronous active-high reset.
module perf_sat_cnt (
    input  logic        clk,
    input  logic        rst,
    input  logic        inc,
    output logic [31:0] cnt
);

    logic [31:0] cnt_r;

    // Counter register; holds at all-ones instead of wrapping.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r <= 32'd0;
        end else if (inc && (cnt_r != 32'hFFFF_FFFF)) begin
            cnt_r <= cnt_r + 32'd1;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign cnt = cnt_r;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencer: stall/flush per pipeline register and exception redirect with deferral
// while a fetch is in flight. Performance counters are built only under PIPE_CTRL_PERF_EN.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        if_stall_req,
    input  logic        id_stall_req,
    input  logic        ex_stall_req,
    input  logic        mem_stall_req,
    input  logic        exc_req,
    input  logic [31:0] exc_target,
    output logic [4:0]  stall,
    output logic [4:0]  flush,
    output logic        redirect,
    output logic [31:0] redirect_pc,
    output logic [31:0] perf_stall_cnt,
    output logic [31:0] perf_exc_cnt
);

    pc_state_e state_r;
    pc_state_e state_nxt_s;
    addr_bus_t pend_pc_r;
    addr_bus_t pend_pc_nxt_s;
    ctrl_bus_t stall_s;
    ctrl_bus_t flush_s;
    logic      redirect_s;
    addr_bus_t redirect_pc_s;

    // State and deferred-target registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= PC_IDLE;
            pend_pc_r <= 32'd0;
        end else begin
            state_r   <= state_nxt_s;
            pend_pc_r <= pend_pc_nxt_s;
        end
    end

    // Next-state and per-register controls; everything is forced quiet during reset.
    always_comb begin
        state_nxt_s   = state_r;
        pend_pc_nxt_s = pend_pc_r;
        stall_s       = 5'b00000;
        flush_s       = 5'b00000;
        redirect_s    = 1'b0;
        redirect_pc_s = 32'd0;
        if (rst) begin
            state_nxt_s   = PC_IDLE;
            pend_pc_nxt_s = 32'd0;
        end else begin
            case (state_r)
                PC_IDLE: begin
                    redirect_pc_s = exc_target;
                    if (exc_req) begin
                        // Exception empties the pipe; MEM never stalls while it raises exc_req.
                        flush_s = 5'b11110;
                        if (if_stall_req) begin
                            stall_s[PC_IDX] = 1'b1;
                            pend_pc_nxt_s   = exc_target;
                            state_nxt_s     = PC_WAIT_IF;
                        end else begin
                            redirect_s = 1'b1;
                        end
                    end else if (mem_stall_req) begin
                        stall_s = 5'b01111;
                        flush_s = 5'b10000;
                    end else if (ex_stall_req) begin
                        stall_s = 5'b00111;
                        flush_s = 5'b01000;
                    end else if (id_stall_req) begin
                        stall_s = 5'b00011;
                        flush_s = 5'b00100;
                    end else if (if_stall_req) begin
                        stall_s = 5'b00001;
                        flush_s = 5'b00010;
                    end else begin
                        stall_s = 5'b00000;
                    end
                end
                PC_WAIT_IF: begin
                    redirect_pc_s     = pend_pc_r;
                    flush_s[IFID_IDX] = 1'b1;
                    if (if_stall_req) begin
                        stall_s[PC_IDX] = 1'b1;
                    end else begin
                        redirect_s  = 1'b1;
                        state_nxt_s = PC_IDLE;
                    end
                end
                default: begin
                    state_nxt_s = PC_IDLE;
                end
            endcase
        end
    end

    assign stall       = stall_s;
    assign flush       = flush_s;
    assign redirect    = redirect_s;
    assign redirect_pc = redirect_pc_s;

`ifdef PIPE_CTRL_PERF_EN
    logic exc_acc_s;
    assign exc_acc_s = !rst && (state_r == PC_IDLE) && exc_req;

    perf_sat_cnt u_stall_cnt (
        .clk (clk),
        .rst (rst),
        .inc (stall_s[PC_IDX]),
        .cnt (perf_stall_cnt)
    );

    perf_sat_cnt u_exc_cnt (
        .clk (clk),
        .rst (rst),
        .inc (exc_acc_s),
        .cnt (perf_exc_cnt)
    );
`else
    assign perf_stall_cnt = 32'd0;
    assign perf_exc_cnt   = 32'd0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed scenarios followed by random traffic,
// all checked against a behavioural model of the sequencing rules.
module tb_pipe_ctrl;

    logic        clk;
    logic        rst;
    logic        if_stall_req;
    logic        id_stall_req;
    logic        ex_stall_req;
    logic        mem_stall_req;
    logic        exc_req;
    logic [31:0] exc_target;
    logic [4:0]  stall;
    logic [4:0]  flush;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] perf_stall_cnt;
    logic [31:0] perf_exc_cnt;

    int total = 0;
    int bad   = 0;

    // Model state: at most one deferred target outstanding.
    logic [31:0] pend_q[$];
    longint      m_stall_cnt = 0;
    longint      m_exc_cnt   = 0;

    pipe_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .if_stall_req   (if_stall_req),
        .id_stall_req   (id_stall_req),
        .ex_stall_req   (ex_stall_req),
        .mem_stall_req  (mem_stall_req),
        .exc_req        (exc_req),
        .exc_target     (exc_target),
        .stall          (stall),
        .flush          (flush),
        .redirect       (redirect),
        .redirect_pc    (redirect_pc),
        .perf_stall_cnt (perf_stall_cnt),
        .perf_exc_cnt   (perf_exc_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One cycle: drive inputs, compare combinational outputs against the model, clock, advance model.
    task automatic step(input logic r, input logic i_s, input logic d_s, input logic e_s,
                        input logic m_s, input logic x, input logic [31:0] tgt);
        logic [4:0]  es;
        logic [4:0]  ef;
        logic        er;
        logic [31:0] ep;
        int          k;
        logic        push;
        logic        pop;
        logic        acc;
        rst = r; if_stall_req = i_s; id_stall_req = d_s; ex_stall_req = e_s;
        mem_stall_req = m_s; exc_req = x; exc_target = tgt;
        #2;
        es = 5'd0; ef = 5'd0; er = 1'b0; ep = 32'd0; push = 1'b0; pop = 1'b0; acc = 1'b0;
        if (r) begin
            es = 5'd0;
        end else if (pend_q.size() != 0) begin
            ef = 5'd2;
            if (i_s) begin
                es = 5'd1;
            end else begin
                er = 1'b1; ep = pend_q[0]; pop = 1'b1;
            end
        end else if (x) begin
            acc = 1'b1;
            ef = 5'b11110;
            if (i_s) begin
                es = 5'd1; push = 1'b1;
            end else begin
                er = 1'b1; ep = tgt;
            end
        end else begin
            k = m_s ? 4 : e_s ? 3 : d_s ? 2 : i_s ? 1 : 0;
            if (k > 0) begin
                es = 5'((1 << k) - 1);
                ef = 5'(1 << k);
            end
        end
        chk("stall", {27'd0, stall}, {27'd0, es});
        chk("flush", {27'd0, flush}, {27'd0, ef});
        chk("redirect", {31'd0, redirect}, {31'd0, er});
        if (er || r) chk("redirect_pc", redirect_pc, ep);
`ifdef PIPE_CTRL_PERF_EN
        chk("perf_stall_cnt", perf_stall_cnt, 32'(m_stall_cnt));
        chk("perf_exc_cnt", perf_exc_cnt, 32'(m_exc_cnt));
`else
        chk("perf_stall_cnt", perf_stall_cnt, 32'd0);
        chk("perf_exc_cnt", perf_exc_cnt, 32'd0);
`endif
        @(posedge clk);
        if (r) begin
            pend_q.delete();
            m_stall_cnt = 0;
            m_exc_cnt = 0;
        end else begin
            if (pop) void'(pend_q.pop_front());
            if (push) pend_q.push_back(tgt);
            if (es[0]) m_stall_cnt++;
            if (acc) m_exc_cnt++;
        end
        #1;
    endtask

    initial begin
        rst = 1'b1; if_stall_req = 1'b0; id_stall_req = 1'b0; ex_stall_req = 1'b0;
        mem_stall_req = 1'b0; exc_req = 1'b0; exc_target = 32'd0;
        @(posedge clk); #1;
        // Reset with noisy requests: outputs must stay quiet.
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 32'hDEAD_BEEF);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        // Single EX stall for three cycles, then release.
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
        chk("ex_stall_const", {27'd0, stall}, 32'd7);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        // IF and MEM together: MEM wins.
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'd0);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
        // Immediate exception.
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'hBFC0_0380);
        // Deferred exception: fetch busy for the request cycle plus two more.
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h8000_0180);
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h1111_1111);
        step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
        if_stall_req = 1'b0; exc_req = 1'b0; #1;
        chk("defer_redirect_const", {31'd0, redirect}, 32'd1);
        chk("defer_pc_const", redirect_pc, 32'h8000_0180);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        // Reset while waiting abandons the pending target.
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'hCAFE_0000);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        // Perf: five stall cycles and two accepted exceptions after a fresh reset.
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0100);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0200);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
`ifdef PIPE_CTRL_PERF_EN
        chk("perf_stall_5", perf_stall_cnt, 32'd5);
        chk("perf_exc_2", perf_exc_cnt, 32'd2);
`else
        chk("perf_stall_off", perf_stall_cnt, 32'd0);
        chk("perf_exc_off", perf_exc_cnt, 32'd0);
`endif
        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 49) == 0) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 2) == 0) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 5) == 0) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 5) == 0) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 7) == 0) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 6) == 0) ? 1'b1 : 1'b0,
                 $urandom);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
